instruc_loader: RTL

Upstream loader for the instruction memory. Receives a byte stream from a serial receiver, assembles 32-bit instructions MSB-first, and writes them to consecutive instruction-memory addresses starting at 0. While a load is in progress it holds the CPU in reset; it releases the CPU only after the final word is written. It sits between the board's byte receiver and the instruction memory's write port and the CPU's reset input.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/instruc_loader_assembler.sv | 50 +++++
 rtl/instruc_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
// FSM encoding plus word geometry helpers.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  localparam int INSTRUC_SIZE_DEF = 32;
  localparam int BYTES_PER_WORD   = INSTRUC_SIZE_DEF / 8;

  function automatic int bytes_per_word(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/instruc_loader_assembler.sv
// Byte-to-word shift assembler, first byte lands in the MSBs.
// word_o/word_ready_o are valid in the cycle the last byte is taken.
module byte_word_assembler
  import loader_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         byte_en_i,
  input  logic [7:0]   byte_i,
  output logic [W-1:0] word_o,
  output logic         word_ready_o
);

  localparam int BPW = bytes_per_word(W);
  localparam int CW  = $clog2(BPW + 1);

  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign word_o       = W'({sh_q, byte_i});
  assign word_ready_o = byte_en_i && (cnt_q == CW'(BPW - 1));

  // Shift in accepted bytes; count restarts after a full word.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (byte_en_i) begin
      sh_d  = word_o;
      cnt_d = word_ready_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instruc_loader.sv
// Serial-byte instruction loader: header count, MSB-first words,
// sequential memory writes, CPU hold and idle timeout.
module instruc_loader
  import loader_pkg::*;
#(
  parameter int INSTRUC_SIZE = 32,
  parameter int ARG_SIZE     = 8,
  parameter int TIMEOUT      = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic                    byte_ready,
  output logic                    mem_wr_en,
  output logic [ARG_SIZE-1:0]     mem_addr,
  output logic [INSTRUC_SIZE-1:0] mem_wr_data,
  output logic                    cpu_hold,
  output logic                    load_done,
  output logic                    load_err,
  output logic [ARG_SIZE:0]       word_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e state_q, state_d;

  logic [ARG_SIZE:0]       n_q, n_d;
  logic [ARG_SIZE:0]       wc_q, wc_d;
  logic [ARG_SIZE:0]       wc_inc;
  logic [ARG_SIZE-1:0]     addr_q, addr_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic                    wr_q, wr_d;
  logic [INSTRUC_SIZE-1:0] wdata_q, wdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    hold_q, hold_d;
  logic                    flush;
  logic                    accept;
  logic                    word_ready;
  logic [INSTRUC_SIZE-1:0] word;

  assign byte_ready  = (state_q == S_HDR) || (state_q == S_DATA);
  assign accept      = byte_valid && byte_ready;
  assign wc_inc      = wc_q + (ARG_SIZE+1)'(1);

  assign mem_wr_en   = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;
  assign cpu_hold    = hold_q;
  assign load_done   = done_q;
  assign load_err    = err_q;
  assign word_count  = wc_q;

  byte_word_assembler #(
    .W(INSTRUC_SIZE)
  ) u_asm (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .byte_en_i   (accept && (state_q == S_DATA)),
    .byte_i      (byte_data),
    .word_o      (word),
    .word_ready_o(word_ready)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wc_d    = wc_q;
    addr_d  = addr_q;
    tmr_d   = tmr_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
    flush   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (arm) begin
          state_d = S_HDR;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wc_d    = '0;
          addr_d  = '0;
          tmr_d   = '0;
          hold_d  = 1'b1;
          flush   = 1'b1;
        end
      end
      S_HDR: begin
        if (accept) begin
          state_d = S_DATA;
          tmr_d   = '0;
          if (byte_data == 8'd0)
            n_d = (ARG_SIZE+1)'(1 << ARG_SIZE);
          else
            n_d = (ARG_SIZE+1)'(byte_data);
        end
      end
      S_DATA: begin
        if (word_ready) begin
          wr_d    = 1'b1;
          wdata_d = word;
        end
        if (wr_q) begin
          addr_d = addr_q + ARG_SIZE'(1);
          wc_d   = wc_inc;
          if (wc_inc == n_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end
        end
        if (accept) begin
          tmr_d = '0;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          if (state_d == S_DATA) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            flush   = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      wc_q    <= '0;
      addr_q  <= '0;
      tmr_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      tmr_q   <= tmr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

endmodule
